// File: rtl/conv1_line_buf_pkg.sv
// conv1_line_buf_pkg
//   Shared geometry for the conv1 window producer and its line FIFOs.
//   IMG_W/IMG_H  image size in pixels
//   K            window size (tap ports fixed at 25, so K is 5)
//   DATA_W       signed pixel width
//   COL_W/ROW_W  counter widths
package conv1_line_buf_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    localparam int DATA_W = 8;
    localparam int N_TAPS = K * K;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
endpackage

// File: rtl/conv1_line_buf_fifo.sv
// conv1_line_fifo
//   IMG_W-deep shift chain that delays the accepted pixel stream by exactly one row.
//   Storage is intentionally not reset.
//   clk   in   clock, rising edge
//   en    in   shift enable (pixel accepted)
//   din   in   pixel entering the chain
//   dout  out  pixel accepted IMG_W enables earlier
module conv1_line_fifo
    import conv1_line_buf_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem_q [IMG_W];
    logic [DATA_W-1:0] mem_d [IMG_W];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < IMG_W; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[IMG_W-1];
endmodule

// File: rtl/conv1_line_buf.sv
// conv1_line_buf
//   Builds a sliding 5x5 window from a raster-scan pixel stream and strobes each
//   valid window position to conv1_calc.
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   valid_in        in   data_in is accepted this cycle
//   data_in         in   signed pixel, raster order
//   data_out_0..24  out  window taps, index r*5+c, row/col 0 oldest
//   valid_out_buf   out  one-cycle strobe: taps form a valid window
//   frame_done      out  one-cycle strobe with the last window of a frame
module conv1_line_buf
    import conv1_line_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out_0,  data_out_1,  data_out_2,  data_out_3,  data_out_4,
    output logic [DATA_W-1:0] data_out_5,  data_out_6,  data_out_7,  data_out_8,  data_out_9,
    output logic [DATA_W-1:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14,
    output logic [DATA_W-1:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19,
    output logic [DATA_W-1:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24,
    output logic              valid_out_buf,
    output logic              frame_done
);
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] win_q [N_TAPS];
    logic [DATA_W-1:0] win_d [N_TAPS];
    logic [DATA_W-1:0] line_in  [K-1];
    logic [DATA_W-1:0] line_out [K-1];

    // line k feeds line k+1, so line k delays by k+1 rows
    for (genvar g = 0; g < K - 1; g++) begin : g_line
        assign line_in[g] = (g == 0) ? data_in : line_out[g-1];
        conv1_line_fifo u_fifo (
            .clk  (clk),
            .en   (valid_in),
            .din  (line_in[g]),
            .dout (line_out[g])
        );
    end

    logic col_last, row_last;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (valid_in) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r*K+c] = win_q[r*K+c+1];
                end
            end
            // newest column: bottom row is the live pixel, oldest row comes from line 3
            win_d[4*K+4] = data_in;
            win_d[3*K+4] = line_out[0];
            win_d[2*K+4] = line_out[1];
            win_d[1*K+4] = line_out[2];
            win_d[0*K+4] = line_out[3];
            valid_d = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
            done_d  = row_last && col_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign valid_out_buf = valid_q;
    assign frame_done    = done_q;

    assign data_out_0  = win_q[0];
    assign data_out_1  = win_q[1];
    assign data_out_2  = win_q[2];
    assign data_out_3  = win_q[3];
    assign data_out_4  = win_q[4];
    assign data_out_5  = win_q[5];
    assign data_out_6  = win_q[6];
    assign data_out_7  = win_q[7];
    assign data_out_8  = win_q[8];
    assign data_out_9  = win_q[9];
    assign data_out_10 = win_q[10];
    assign data_out_11 = win_q[11];
    assign data_out_12 = win_q[12];
    assign data_out_13 = win_q[13];
    assign data_out_14 = win_q[14];
    assign data_out_15 = win_q[15];
    assign data_out_16 = win_q[16];
    assign data_out_17 = win_q[17];
    assign data_out_18 = win_q[18];
    assign data_out_19 = win_q[19];
    assign data_out_20 = win_q[20];
    assign data_out_21 = win_q[21];
    assign data_out_22 = win_q[22];
    assign data_out_23 = win_q[23];
    assign data_out_24 = win_q[24];
endmodule

// File: tb/tb_conv1_line_buf.sv
module tb_conv1_line_buf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12;
    logic [7:0] d13, d14, d15, d16, d17, d18, d19, d20, d21, d22, d23, d24;
    logic       valid_out_buf, frame_done;
    logic [199:0] taps;

    always #5 clk = ~clk;

    conv1_line_buf dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .data_out_0(d0),   .data_out_1(d1),   .data_out_2(d2),   .data_out_3(d3),   .data_out_4(d4),
        .data_out_5(d5),   .data_out_6(d6),   .data_out_7(d7),   .data_out_8(d8),   .data_out_9(d9),
        .data_out_10(d10), .data_out_11(d11), .data_out_12(d12), .data_out_13(d13), .data_out_14(d14),
        .data_out_15(d15), .data_out_16(d16), .data_out_17(d17), .data_out_18(d18), .data_out_19(d19),
        .data_out_20(d20), .data_out_21(d21), .data_out_22(d22), .data_out_23(d23), .data_out_24(d24),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
    );

    assign taps = {d24, d23, d22, d21, d20, d19, d18, d17, d16, d15, d14, d13, d12,
                   d11, d10, d9, d8, d7, d6, d5, d4, d3, d2, d1, d0};

    // reference model: the frame as a 2-D image, window taken directly from it
    logic [7:0]   img [28][28];
    int           cr, cc, accepted, first_strobe;
    int           dut_strobes, dut_done, row_cnt [28];
    int           bad_col_strobes;
    logic [199:0] exp_win;
    bit           have_win;
    logic [7:0]   first_t0, first_t24, last_t0, last_t24;
    bit           last_done;
    int           n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [199:0] window_at(input int r, input int c);
        logic [199:0] w;
        for (int i = 0; i < 25; i++) w[i*8 +: 8] = img[r - 4 + i / 5][c - 4 + i % 5];
        return w;
    endfunction

    task automatic model_reset();
        cr = 0; cc = 0; accepted = 0; first_strobe = -1;
        dut_strobes = 0; dut_done = 0; bad_col_strobes = 0;
        for (int i = 0; i < 28; i++) row_cnt[i] = 0;
        exp_win = '0; have_win = 1'b1;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        logic ev, efd;
        int   r, c;
        valid_in = v; data_in = d;
        @(posedge clk); #1;
        ev = 1'b0; efd = 1'b0; r = cr; c = cc;
        if (v) begin
            img[r][c] = d;
            accepted++;
            ev  = (r >= 4) && (c >= 4);
            efd = (r == 27) && (c == 27);
            if (ev) begin exp_win = window_at(r, c); have_win = 1'b1; end
            else have_win = 1'b0;
            cc = (cc == 27) ? 0 : cc + 1;
            if (c == 27) cr = (cr == 27) ? 0 : cr + 1;
        end
        chk("valid_out_buf", 200'(valid_out_buf), 200'(ev));
        chk("frame_done", 200'(frame_done), 200'(efd));
        if (have_win) chk("taps", taps, exp_win);
        if (valid_out_buf) begin
            dut_strobes++;
            if (v) row_cnt[r]++;
            if (v && c < 4) bad_col_strobes++;
            if (first_strobe < 0) begin first_strobe = accepted; first_t0 = d0; first_t24 = d24; end
            last_t0 = d0; last_t24 = d24; last_done = frame_done;
        end
        if (frame_done) dut_done++;
    endtask

    // mode 0 ramp, 1 random, 2 constant 8'h80; gap_pct = chance of an idle cycle
    task automatic run_pixels(input int n, input int mode, input int gap_pct);
        logic [7:0] p;
        int sent = 0;
        while (sent < n) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                step(1'b0, 8'($urandom));
            end else begin
                case (mode)
                    0:       p = 8'((cr * 28 + cc) % 128);
                    1:       p = 8'($urandom);
                    default: p = 8'h80;
                endcase
                step(1'b1, p);
                sent++;
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_valid", 200'(valid_out_buf), 200'(0));
        chk("reset_done", 200'(frame_done), 200'(0));
        chk("reset_taps", taps, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1 + 6: ramp frame, continuous
        run_pixels(784, 0, 0);
        chk("ramp_strobes", 200'(dut_strobes), 200'(576));
        chk("ramp_first_idx", 200'(first_strobe), 200'(117));
        chk("ramp_first_t0", 200'(first_t0), 200'(0));
        chk("ramp_first_t24", 200'(first_t24), 200'(116));
        chk("ramp_last_t0", 200'(last_t0), 200'(27));
        chk("ramp_last_t24", 200'(last_t24), 200'(15));
        chk("ramp_last_done", 200'(last_done), 200'(1));
        chk("ramp_done_cnt", 200'(dut_done), 200'(1));
        chk("ramp_col_lt4", 200'(bad_col_strobes), 200'(0));
        for (int r = 0; r < 28; r++) chk($sformatf("row_cnt_%0d", r), 200'(row_cnt[r]), 200'(r < 4 ? 0 : 24));

        // 2: ramp with random gaps
        dut_strobes = 0; dut_done = 0;
        run_pixels(784, 0, 50);
        step(1'b0, 8'h00);
        chk("gap_strobes", 200'(dut_strobes), 200'(576));
        chk("gap_done_cnt", 200'(dut_done), 200'(1));

        // 3: two random frames back-to-back
        dut_strobes = 0; dut_done = 0;
        run_pixels(1568, 1, 0);
        chk("b2b_strobes", 200'(dut_strobes), 200'(1152));
        chk("b2b_done_cnt", 200'(dut_done), 200'(2));

        // 5: all -128
        dut_strobes = 0;
        run_pixels(784, 2, 10);
        chk("neg_strobes", 200'(dut_strobes), 200'(576));
        chk("neg_last_t0", 200'(last_t0), 200'(8'h80));

        // 4: reset mid-frame after accepting (10,3)
        run_pixels(10 * 28 + 4, 1, 20);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 200'(valid_out_buf), 200'(0));
        chk("midrst_done", 200'(frame_done), 200'(0));
        chk("midrst_taps", taps, '0);
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;              // released in the same cycle valid_in is high
        run_pixels(200, 1, 30);
        chk("midrst_first_idx", 200'(first_strobe), 200'(117));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
